// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the registered grant.
interface rr_arbiter_8_if #(
  parameter int NREQ = 8,
  parameter int IDW  = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant and encoded ID.
// The holder keeps the grant while its request stays high; define ARB_TIMEOUT_EN to force a handoff after MAX_HOLD cycles.
module rr_arbiter_8 #(
  parameter int NREQ     = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_8_if.slave bus
);

  if (IDW != $clog2(NREQ) || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arbiter_8: IDW must equal clog2(NREQ) and MAX_HOLD must be >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  win_id, idx;
  logic            win_found, take_win, holder_req;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  // The current holder is always masked out; when it drops req this is the
  // zero-bubble re-arbitration, when it is being timed out it must not re-win.
  // NOTE: combinational blocks use blocking '=' with every output defaulted first,
  // so later statements see earlier results and no latch can be inferred.
  always_comb begin
    cand      = bus.req & ~gnt_q;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + IDW'(i);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign holder_req = bus.req[gnt_id_q];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    take_win = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) take_win = 1'b1;
      end
      GRANT: begin
        if (!holder_req) begin
          if (win_found) begin
            take_win = 1'b1;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HW'(MAX_HOLD) && win_found) begin
          take_win  = 1'b1;
          timeout_d = 1'b1;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: ;
    endcase

    if (take_win) begin
      state_d  = GRANT;
      gnt_d    = NREQ'(1) << win_id;
      gnt_id_d = win_id;
      ptr_d    = win_id + 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_d   = HW'(1);
`endif
    end
  end

  // NOTE: state registers use non-blocking '<=' and a synchronous reset that is
  // only evaluated at the clock edge, so a mid-grant reset simply drops the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
